fir_mac_ctrl: RTL and testbench
===============================

Name: fir_mac_ctrl

Overview:
Sequencer and multiply-accumulate datapath that sits directly downstream of shreg_stack. On each accepted input sample it:
- pulses the stack's shift-enable,
- walks the stack read address over all taps,
- multiplies each tap by the matching coefficient and accumulates,
- presents one filtered output sample under a valid/ready handshake.

Coefficients come from an external combinational ROM addressed by the same tap index.

Parameters:
- TAPS, 64, number of filter taps; equals STACK_SIZE of the attached shreg_stack; must be ≥ 2.
- DATA_WIDTH, 16, signed sample width; equals the shreg_stack DATA_WIDTH.
- COEF_WIDTH, 16, signed coefficient width.
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(TAPS), accumulator and output width; full precision, no overflow possible.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- in_data  input  DATA_WIDTH  signed input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample.
- stack_din  output  DATA_WIDTH  to shreg_stack in; combinational copy of in_data.
- stack_ld  output  1  to shreg_stack ld_in; equals in_valid & in_ready.
- stack_adr  output  $clog2(TAPS)  to shreg_stack adr; tap index, 0 = newest sample.
- stack_dout  input  DATA_WIDTH  from shreg_stack out; signed tap value at stack_adr, combinational.
- coef_adr  output  $clog2(TAPS)  coefficient ROM address; always equal to stack_adr.
- coef_in  input  COEF_WIDTH  signed coefficient at coef_adr, combinational.
- out_data  output  ACC_WIDTH  signed filter result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- One clock only. Reset is asynchronous and active-low (rst=0).
- Reset values: state=IDLE, tap index=0, acc=0, out_valid=0, out_data=0. in_ready is 1 immediately after reset (combinational from IDLE).
- States: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - stack_ld = in_valid, so the stack shifts in in_data on the same edge.
  - On in_valid: next state MAC, tap index←0, acc←0.
- MAC:
  - in_ready=0, stack_ld=0.
  - Each cycle: acc ← acc + sext(stack_dout) * sext(coef_in), signed multiply, full-width sign extension to ACC_WIDTH.
  - Tap index increments each cycle.
  - When tap index == TAPS-1: that product is still added, tap index←0, next state DONE.
  - Exactly TAPS MAC cycles occur per sample.
- DONE:
  - out_valid=1, out_data=acc; both held stable while out_ready=0.
  - On out_ready: next state IDLE, out_valid←0.
  - A new sample cannot be accepted in the same cycle as the output transfer; the earliest acceptance is the following cycle.
- Latency: sample accepted at edge E0 → out_valid rises after edge E0+TAPS. Minimum throughput is one sample per TAPS+2 cycles.
- in_valid while not IDLE: ignored, no stack shift, in_data not captured. The source must hold in_valid/in_data until in_ready.
- Wrap-around: the tap index never exceeds TAPS-1, so stack_adr is always in range. Index TAPS-1 reads the oldest tap.
- Reset mid-MAC or mid-DONE: partial acc and pending output are discarded; return to IDLE. shreg_stack contents are reset by its own reset.
- stack_adr/coef_adr equal the tap index in MAC and are 0 in IDLE and DONE.

Decomposition:
- Package fir_pkg holds:
  - the state enum typedef (IDLE, MAC, DONE);
  - localparam helpers for tap-index width and ACC_WIDTH.
- One sub-module, fir_mac_unit: signed multiply plus accumulate register, with clear and enable inputs and async active-low reset. The FSM and tap counter stay in fir_mac_ctrl.

Test Plan:
Common setup: TAPS=4, DATA_WIDTH=8, COEF_WIDTH=8; ROM coefficients [1,2,3,4]; a real shreg_stack is attached; out_ready=1 unless stated.
1. Reset, then sample 10 → stack_ld pulses for exactly 1 cycle; out_data=10; out_valid rises 4 cycles after acceptance and stays high 1 cycle.
2. Then sample 20 → out_data = 20·1 + 10·2 = 40. Then sample 30 → out_data = 30 + 40 + 30 = 100.
3. Signed arithmetic: fresh reset, then samples -128, 127 → outputs -128, then 127·1 + (-128)·2 = -129. Coefficients all -128 with sample -128 → out_data = +16384, no overflow.
4. Backpressure: out_ready=0 for 5 cycles in DONE → out_data stable, in_ready=0. A new in_valid raised in that window is not shifted in (stack_ld stays 0) and is accepted one cycle after the output transfer.
5. Reset asserted on MAC cycle 2 → out_valid stays 0, state is IDLE, in_ready=1. The next sample 7 produces out_data = 7.
6. Tap walk check: for one sample, stack_adr sequence is 0,1,2,3 then 0, and coef_adr matches it every cycle.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and width helpers for the FIR MAC sequencer.
//   state_e   - sequencer states (IDLE, MAC, DONE)
//   idx_width - tap-index width for a given tap count
//   acc_width - full-precision accumulator width (no overflow over all taps)
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: signed multiply-accumulate register.
//   clk, rst  - clock, async active-low reset
//   clr_i     - load zero into the accumulator (wins over en_i)
//   en_i      - add a_i*b_i to the accumulator
//   a_i, b_i  - signed operands
//   acc_o     - registered signed accumulator
module fir_mac_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 38
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [COEF_WIDTH-1:0] b_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;

  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  // Operands sign-extended to product width before multiplying
  assign prod = PROD_W'(a_i) * PROD_W'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: sequencer driving a shift-register tap stack and a MAC unit.
//   clk, rst              - clock, async active-low reset
//   in_data/valid/ready   - input sample handshake (ready only in IDLE)
//   stack_din, stack_ld   - shift a new sample into the tap stack
//   stack_adr, stack_dout - tap read address / tap value (0 = newest)
//   coef_adr, coef_in     - coefficient ROM address / value (same index)
//   out_data/valid/ready  - filtered result handshake
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter  int unsigned TAPS       = 64,
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned COEF_WIDTH = 16,
  localparam int unsigned IDX_W      = idx_width(TAPS),
  localparam int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] stack_din,
  output logic                         stack_ld,
  output logic        [IDX_W-1:0]      stack_adr,
  input  logic signed [DATA_WIDTH-1:0] stack_dout,
  output logic        [IDX_W-1:0]      coef_adr,
  input  logic signed [COEF_WIDTH-1:0] coef_in,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             mac_clr;
  logic             mac_en;

  // Handshake and stack controls are combinational from the current state
  assign in_ready  = (state_q == IDLE);
  assign stack_ld  = in_valid & in_ready;
  assign stack_din = in_data;
  // Index is forced back to 0 on leaving MAC, so it reads 0 in IDLE/DONE
  assign stack_adr = idx_q;
  assign coef_adr  = idx_q;
  assign out_valid = out_valid_q;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MAC;
          idx_d   = '0;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        // Last tap still contributes its product on this edge
        if (idx_q == IDX_W'(TAPS - 1)) begin
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Accumulator doubles as the held output register in DONE
  fir_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (stack_dout),
    .b_i   (coef_in),
    .acc_o (out_data)
  );

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb_fir_mac_ctrl: self-checking bench for fir_mac_ctrl with TAPS=4, 8-bit
// data/coefficients, a behavioural tap stack and coefficient ROM, and a
// sample-history reference model.
module tb_fir_mac_ctrl;

  localparam int unsigned TAPS = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 8;
  localparam int unsigned IW   = 2;
  localparam int unsigned AW   = 18;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] stack_din;
  logic                 stack_ld;
  logic [IW-1:0]        stack_adr;
  logic signed [DW-1:0] stack_dout;
  logic [IW-1:0]        coef_adr;
  logic signed [CW-1:0] coef_in;
  logic signed [AW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  logic signed [DW-1:0] stk [TAPS];
  logic signed [CW-1:0] rom [TAPS];

  int checks;
  int failures;
  int hist[$];

  fir_mac_ctrl #(
    .TAPS       (TAPS),
    .DATA_WIDTH (DW),
    .COEF_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stack_din  (stack_din),
    .stack_ld   (stack_ld),
    .stack_adr  (stack_adr),
    .stack_dout (stack_dout),
    .coef_adr   (coef_adr),
    .coef_in    (coef_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached shift-register stack: newest sample at address 0
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) stk[i] <= '0;
    end else if (stack_ld) begin
      stk[0] <= stack_din;
      for (int i = 1; i < TAPS; i++) stk[i] <= stk[i-1];
    end
  end

  assign stack_dout = stk[stack_adr];
  assign coef_in    = rom[coef_adr];

  // Dot product of coefficient table with the newest-first sample history
  function automatic logic signed [AW-1:0] expected();
    int acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      if (k < hist.size()) acc += int'(rom[k]) * hist[k];
    end
    return AW'(acc);
  endfunction

  task automatic set_rom(input int c0, input int c1, input int c2, input int c3);
    rom[0] = CW'(c0);
    rom[1] = CW'(c1);
    rom[2] = CW'(c2);
    rom[3] = CW'(c3);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hist.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one sample through accept, MAC walk, result and optional stall.
  // With chain set, the next sample is raised during the stall window.
  task automatic process_sample(input int s, input int stall, input bit chain, input int next_s);
    logic signed [AW-1:0] exp_v;
    bit got;
    in_data   = DW'(s);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    #1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      return;
    end
    checks++;
    if (stack_ld !== 1'b1) begin
      failures++;
      $display("FAIL stack_ld_accept got=%0b exp=1", stack_ld);
    end
    @(posedge clk);
    hist.push_front(s);
    if (hist.size() > TAPS) void'(hist.pop_back());
    exp_v = expected();
    // in_valid stays high through MAC: it must be ignored there
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      checks++;
      if (stack_adr !== IW'(k) || coef_adr !== IW'(k)) begin
        failures++;
        $display("FAIL tap_walk k=%0d stack_adr=%0d coef_adr=%0d exp=%0d", k, stack_adr, coef_adr, k);
      end
      checks++;
      if (out_valid !== 1'b0 || stack_ld !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL mac_flags k=%0d out_valid=%0b stack_ld=%0b in_ready=%0b exp=0,0,0",
                 k, out_valid, stack_ld, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency out_valid=%0b exp=1", out_valid);
    end
    checks++;
    if (out_data !== exp_v) begin
      failures++;
      $display("FAIL out_data got=%0d exp=%0d", out_data, exp_v);
    end
    checks++;
    if (stack_adr !== '0 || coef_adr !== '0) begin
      failures++;
      $display("FAIL adr_done stack_adr=%0d coef_adr=%0d exp=0", stack_adr, coef_adr);
    end
    for (int j = 0; j < stall; j++) begin
      if (chain && j == 0) begin
        in_data  = DW'(next_s);
        in_valid = 1'b1;
        #1;
      end
      checks++;
      if (stack_ld !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_flags j=%0d stack_ld=%0b in_ready=%0b exp=0,0", j, stack_ld, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        failures++;
        $display("FAIL stall_hold j=%0d out_valid=%0b out_data=%0d exp=1,%0d", j, out_valid, out_data, exp_v);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release out_valid=%0b in_ready=%0b exp=0,1", out_valid, in_ready);
    end
    if (chain && stall > 0) begin
      checks++;
      if (stack_ld !== 1'b1) begin
        failures++;
        $display("FAIL pending_accept stack_ld=%0b exp=1", stack_ld);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    hist.delete();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_out out_valid=%0b out_data=%0d exp=0,0", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b1 || stack_adr !== '0 || stack_ld !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl in_ready=%0b stack_adr=%0d stack_ld=%0b exp=1,0,0", in_ready, stack_adr, stack_ld);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset in_ready=%0b out_valid=%0b exp=1,0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    set_rom(1, 2, 3, 4);
    process_sample(10, 0, 1'b0, 0);
    process_sample(20, 0, 1'b0, 0);
    process_sample(30, 0, 1'b0, 0);
  endtask

  task automatic test_signed();
    apply_reset();
    set_rom(1, 2, 3, 4);
    process_sample(-128, 0, 1'b0, 0);
    process_sample(127, 0, 1'b0, 0);
    apply_reset();
    set_rom(-128, -128, -128, -128);
    process_sample(-128, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_rom(1, 2, 3, 4);
    process_sample(5, 5, 1'b1, 9);
    process_sample(9, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_mac();
    apply_reset();
    set_rom(1, 2, 3, 4);
    process_sample(3, 0, 1'b0, 0);
    in_data  = DW'(50);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stack_adr !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL mid_mac_reset out_valid=%0b in_ready=%0b stack_adr=%0d out_data=%0d exp=0,1,0,0",
               out_valid, in_ready, stack_adr, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_mac_idle i=%0d out_valid=%0b in_ready=%0b exp=0,1", i, out_valid, in_ready);
      end
    end
    process_sample(7, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    int smp[40];
    int stall;
    bit chain;
    apply_reset();
    for (int i = 0; i < TAPS; i++) rom[i] = CW'($urandom_range(0, 255));
    for (int n = 0; n < 40; n++) smp[n] = int'($urandom_range(0, 255)) - 128;
    for (int n = 0; n < 40; n++) begin
      stall = int'($urandom_range(0, 3));
      chain = (stall > 0) && ($urandom_range(0, 1) == 1) && (n < 39);
      process_sample(smp[n], stall, chain, (n < 39) ? smp[n+1] : 0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    set_rom(1, 2, 3, 4);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
